mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 33 +++
 rtl/mem_access_unit_load_extend.sv | 25 ++
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store bus access unit.
package mem_access_pkg;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    // Unlisted encodings (011/110/111) fall through to word accesses.
    function automatic size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = SZ_B;
            F3_H, F3_HU: f3_size = SZ_H;
            default:     f3_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load lane alignment: shifts the bus word down by the byte offset and sign/zero extends.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic        sext;

    always_comb begin
        shifted = word_i >> {off_i, 3'b000};
        sext    = ~funct3_i[2];
        data_o  = shifted;
        case (f3_size(funct3_i))
            SZ_B:    data_o = {{24{sext & shifted[7]}}, shifted[7:0]};
            SZ_H:    data_o = {{16{sext & shifted[15]}}, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit bridging the pipeline to a request/ack bus with timeout.
// Define MISALIGN_TRAP_EN to abort misaligned H/W accesses with misalign_err.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err,
    output logic        misalign_err
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] ext_data;
    size_e       size;
    logic [1:0]  off_eff;
`ifdef MISALIGN_TRAP_EN
    logic        mis_q, mis_d;
    logic        misaligned;
`endif

    load_extend u_load_extend (
        .word_i  (bus_rdata),
        .off_i   (addr_q[1:0]),
        .funct3_i(f3_q),
        .data_o  (ext_data)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef MISALIGN_TRAP_EN
        mis_d      = mis_q;
        misaligned = 1'b0;
`endif
        size    = f3_size(funct3);
        off_eff = addr[1:0];

        case (state_q)
            IDLE: begin
                if (mem_read | mem_write) begin
                    // Low address bits beyond the access width are dropped so the
                    // lane shift and byte enables stay naturally aligned.
                    case (size)
                        SZ_B: begin
                            off_eff = addr[1:0];
                            be_d    = 4'b0001 << addr[1:0];
                            wdata_d = {4{wdata[7:0]}};
                        end
                        SZ_H: begin
                            off_eff = {addr[1], 1'b0};
                            be_d    = 4'b0011 << {addr[1], 1'b0};
                            wdata_d = {2{wdata[15:0]}};
                        end
                        default: begin
                            off_eff = 2'b00;
                            be_d    = 4'b1111;
                            wdata_d = wdata;
                        end
                    endcase
                    addr_d  = {addr[31:2], off_eff};
                    f3_d    = funct3;
                    we_d    = mem_write;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = REQ;
`ifdef MISALIGN_TRAP_EN
                    misaligned = ((size == SZ_H) && addr[0]) ||
                                 ((size == SZ_W) && (addr[1:0] != 2'b00));
                    if (misaligned) begin
                        mis_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end
`endif
                end
            end
            REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (bus_ack) begin
                    rdata_d = ext_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                err_d   = 1'b0;
`ifdef MISALIGN_TRAP_EN
                mis_d   = 1'b0;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign bus_req   = (state_q == REQ);
    assign done      = (state_q == RESP);
    assign stall     = (state_q == REQ) || ((state_q == IDLE) && (mem_read || mem_write));
    assign bus_we    = we_q;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_wdata = wdata_q;
    assign bus_be    = be_q;
    assign rdata     = rdata_q;
    assign bus_err   = err_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_err = mis_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule
